// File: rtl/noc_ibuf_pkg.sv
// Shared constants and helpers for the NoC router input buffer array.
package noc_ibuf_pkg;

   localparam int NUM_PORTS_DEF = 5;
   localparam int DATA_W_DEF    = 32;
   localparam int DEPTH_DEF     = 4;

   localparam int PORT_N = 0;
   localparam int PORT_S = 1;
   localparam int PORT_E = 2;
   localparam int PORT_W = 3;
   localparam int PORT_L = 4;

   // Occupancy counter width: must represent 0..DEPTH inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/noc_input_buffer_array_if.sv
// Upstream-link / allocator-side bundle of the input buffer array, all per-port signals packed.
interface noc_input_buffer_array_if
   import noc_ibuf_pkg::*;
#(
   parameter int NUM_PORTS = NUM_PORTS_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int DEPTH     = DEPTH_DEF
) ();

   localparam int CNT_W = cnt_w(DEPTH);

   logic [NUM_PORTS-1:0]              valid_i;
   logic [NUM_PORTS-1:0][DATA_W-1:0]  data_i;
   logic [NUM_PORTS-1:0]              pop_req_i;
   logic [NUM_PORTS-1:0]              grant_i;
   logic [NUM_PORTS-1:0]              valid_o;
   logic [NUM_PORTS-1:0][DATA_W-1:0]  data_o;
   logic [NUM_PORTS-1:0]              mask_o;
   logic [NUM_PORTS-1:0][CNT_W-1:0]   count_o;
   logic [NUM_PORTS-1:0]              full_o;
   logic [NUM_PORTS-1:0]              ovf_o;
   logic [NUM_PORTS-1:0]              credit_o;

   modport master (
      output valid_i, data_i, pop_req_i, grant_i,
      input  valid_o, data_o, mask_o, count_o, full_o, ovf_o, credit_o
   );

   modport slave (
      input  valid_i, data_i, pop_req_i, grant_i,
      output valid_o, data_o, mask_o, count_o, full_o, ovf_o, credit_o
   );

endinterface

// File: rtl/ibuf_fifo.sv
// One input port: circular FIFO with head lock (mask), overflow pulse and credit return.
// Credit return and the overflow protocol check are built only with INBUF_CREDIT_EN defined.
module ibuf_fifo
   import noc_ibuf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int CNT_W  = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_vld,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop_req,
   input  logic              grant,
   output logic              head_vld,
   output logic [DATA_W-1:0] head_data,
   output logic              mask,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              ovf,
   output logic              credit
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W-1:0]  fill;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              empty, pop, push;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign fill  = wr_ptr - rd_ptr;
   assign count = CNT_W'(fill);

   assign pop  = pop_req & grant & ~empty;
   assign push = push_vld & (~full | pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the head is gated to zero whenever the port is empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head_vld  = ~empty;
   assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf  <= 1'b0;
         mask <= 1'b0;
      end else begin
         ovf <= push_vld & full & ~pop;
         if (pop)
            mask <= 1'b0;
         else if (grant && !empty)
            mask <= 1'b1;
      end
   end

`ifdef INBUF_CREDIT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) credit <= 1'b0;
      else      credit <= pop;
   end

   // With credit flow control an upstream push into a full port is a protocol error.
   a_no_ovf : assert property (@(posedge clk) disable iff (!rst) !ovf)
      else $error("ibuf_fifo: push dropped on full port under credit flow control");
`else
   assign credit = 1'b0;
`endif

endmodule

// File: rtl/noc_input_buffer_array.sv
// NUM_PORTS independent input FIFOs in front of the switch allocator; slicing only.
// Optional credit return selected by INBUF_CREDIT_EN.
module noc_input_buffer_array
   import noc_ibuf_pkg::*;
#(
   parameter int NUM_PORTS = NUM_PORTS_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int DEPTH     = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   noc_input_buffer_array_if.slave  bus
);

   localparam int CNT_W = cnt_w(DEPTH);

   logic [NUM_PORTS-1:0]             valid_o, mask_o, full_o, ovf_o, credit_o;
   logic [NUM_PORTS-1:0][DATA_W-1:0] data_o;
   logic [NUM_PORTS-1:0][CNT_W-1:0]  count_o;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      ibuf_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH),
         .CNT_W  (CNT_W)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push_vld  (bus.valid_i[p]),
         .push_data (bus.data_i[p]),
         .pop_req   (bus.pop_req_i[p]),
         .grant     (bus.grant_i[p]),
         .head_vld  (valid_o[p]),
         .head_data (data_o[p]),
         .mask      (mask_o[p]),
         .count     (count_o[p]),
         .full      (full_o[p]),
         .ovf       (ovf_o[p]),
         .credit    (credit_o[p])
      );
   end

   assign bus.valid_o  = valid_o;
   assign bus.data_o   = data_o;
   assign bus.mask_o   = mask_o;
   assign bus.count_o  = count_o;
   assign bus.full_o   = full_o;
   assign bus.ovf_o    = ovf_o;
   assign bus.credit_o = credit_o;

endmodule

// File: tb/tb_noc_input_buffer_array.sv
// Randomized self-checking bench for noc_input_buffer_array against a queue-based port model.
module tb_noc_input_buffer_array;
   import noc_ibuf_pkg::*;

   localparam int NP = NUM_PORTS_DEF;
   localparam int DW = DATA_W_DEF;
   localparam int DP = DEPTH_DEF;
   localparam int CW = cnt_w(DP);
`ifdef INBUF_CREDIT_EN
   localparam bit CREDIT_EN = 1'b1;
`else
   localparam bit CREDIT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   noc_input_buffer_array_if #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DP)) bus ();

   noc_input_buffer_array #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [DW-1:0] q [NP][$];
   logic [NP-1:0] m_mask, m_ovf, m_credit;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [NP-1:0]         ev, ef;
      logic [NP-1:0][DW-1:0] ed;
      logic [NP-1:0][CW-1:0] ec;
      for (int p = 0; p < NP; p++) begin
         ev[p] = q[p].size() > 0;
         ed[p] = ev[p] ? q[p][0] : '0;
         ec[p] = CW'(q[p].size());
         ef[p] = q[p].size() == DP;
      end
      chk({tag, ".valid"},  256'(bus.valid_o),  256'(ev));
      chk({tag, ".data"},   256'(bus.data_o),   256'(ed));
      chk({tag, ".count"},  256'(bus.count_o),  256'(ec));
      chk({tag, ".full"},   256'(bus.full_o),   256'(ef));
      chk({tag, ".ovf"},    256'(bus.ovf_o),    256'(m_ovf));
      chk({tag, ".mask"},   256'(bus.mask_o),   256'(m_mask));
      chk({tag, ".credit"}, 256'(bus.credit_o), 256'(m_credit));
   endtask

   // Apply the current inputs to the model, advance one clock, then compare.
   task automatic tick(input string tag);
      bit pop, push, full;
      for (int p = 0; p < NP; p++) begin
         full = q[p].size() == DP;
         pop  = bus.pop_req_i[p] && bus.grant_i[p] && q[p].size() > 0;
         push = bus.valid_i[p] && (!full || pop);
         m_ovf[p]    = bus.valid_i[p] && full && !pop;
         m_credit[p] = CREDIT_EN && pop;
         if (pop) m_mask[p] = 1'b0;
         else if (bus.grant_i[p] && q[p].size() > 0) m_mask[p] = 1'b1;
         if (pop)  void'(q[p].pop_front());
         if (push) q[p].push_back(bus.data_i[p]);
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic clear_in();
      bus.valid_i   = '0;
      bus.data_i    = '0;
      bus.pop_req_i = '0;
      bus.grant_i   = '0;
   endtask

   task automatic model_reset();
      for (int p = 0; p < NP; p++) q[p].delete();
      m_mask   = '0;
      m_ovf    = '0;
      m_credit = '0;
   endtask

   int credit_seen;

   initial begin
      clear_in();
      model_reset();
      #2 rst = 1'b0;
      #1 check_all("reset");
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // single push on port N
      bus.valid_i[PORT_N] = 1'b1;
      bus.data_i[PORT_N]  = 32'hA5A5_0001;
      tick("push0");
      clear_in();
      chk("push0.head", 256'(bus.data_o[PORT_N]), 256'(32'hA5A5_0001));
      chk("push0.others", 256'(bus.valid_o), 256'(1));
      bus.pop_req_i[PORT_N] = 1'b1;
      bus.grant_i[PORT_N]   = 1'b1;
      tick("drain0");
      clear_in();

      // fill port S past capacity (no overflow attempt under credit control)
      for (int i = 0; i < DP + 1; i++) begin
         bus.valid_i[PORT_S] = CREDIT_EN ? (i < DP) : 1'b1;
         bus.data_i[PORT_S]  = 32'h1000_0000 + i;
         tick("fill");
      end
      clear_in();
      chk("fill.full", 256'(bus.full_o[PORT_S]), 256'(1));
      tick("ovf_end");

      // full port with simultaneous push and pop, long enough to wrap
      for (int i = 0; i < 20; i++) begin
         bus.valid_i[PORT_S]   = 1'b1;
         bus.data_i[PORT_S]    = 32'h2000_0000 + i;
         bus.pop_req_i[PORT_S] = 1'b1;
         bus.grant_i[PORT_S]   = 1'b1;
         tick("pushpop");
      end
      clear_in();
      chk("pushpop.count", 256'(bus.count_o[PORT_S]), 256'(DP));
      for (int i = 0; i < DP; i++) begin
         bus.pop_req_i[PORT_S] = 1'b1;
         bus.grant_i[PORT_S]   = 1'b1;
         tick("drain1");
      end
      clear_in();

      // lock: grant without pop_req, grant drop, then pop
      for (int i = 0; i < 2; i++) begin
         bus.valid_i[PORT_E] = 1'b1;
         bus.data_i[PORT_E]  = 32'h3000_0000 + i;
         tick("lock.fill");
      end
      clear_in();
      for (int i = 0; i < 3; i++) begin
         bus.grant_i[PORT_E] = 1'b1;
         tick("lock.grant");
      end
      chk("lock.mask", 256'(bus.mask_o[PORT_E]), 256'(1));
      clear_in();
      tick("lock.hold");
      bus.pop_req_i[PORT_E] = 1'b1;
      bus.grant_i[PORT_E]   = 1'b1;
      tick("lock.pop");
      clear_in();
      chk("lock.head", 256'(bus.data_o[PORT_E]), 256'(32'h3000_0001));

      // credit return on port L
      for (int i = 0; i < 3; i++) begin
         bus.valid_i[PORT_L] = 1'b1;
         bus.data_i[PORT_L]  = 32'h4000_0000 + i;
         tick("credit.fill");
      end
      clear_in();
      credit_seen = 0;
      for (int i = 0; i < 3; i++) begin
         bus.pop_req_i[PORT_L] = 1'b1;
         bus.grant_i[PORT_L]   = 1'b1;
         tick("credit.pop");
         if (bus.credit_o[PORT_L]) credit_seen++;
         clear_in();
         tick("credit.idle");
         if (bus.credit_o[PORT_L]) credit_seen++;
      end
      chk("credit.total", 256'(credit_seen), 256'(CREDIT_EN ? 3 : 0));

      // random traffic on all ports
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NP; p++) begin
            bus.valid_i[p]   = ($urandom_range(0, 99) < 60);
            bus.data_i[p]    = $urandom;
            bus.pop_req_i[p] = ($urandom_range(0, 99) < 50);
            bus.grant_i[p]   = ($urandom_range(0, 99) < 60);
            if (CREDIT_EN && q[p].size() == DP && !(bus.pop_req_i[p] && bus.grant_i[p]))
               bus.valid_i[p] = 1'b0;
         end
         tick("rand");
      end
      clear_in();

      // drain, refill to 3 everywhere, then reset mid-traffic
      for (int i = 0; i < DP; i++) begin
         bus.pop_req_i = '1;
         bus.grant_i   = '1;
         tick("rst.drain");
      end
      clear_in();
      for (int i = 0; i < 3; i++) begin
         for (int p = 0; p < NP; p++) begin
            bus.valid_i[p] = 1'b1;
            bus.data_i[p]  = $urandom;
         end
         tick("rst.fill");
      end
      bus.grant_i = '1;
      #2 rst = 1'b0;
      model_reset();
      #1 check_all("rst.async");
      @(posedge clk); #1;
      check_all("rst.hold");
      clear_in();
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
         bus.valid_i[p] = 1'b1;
         bus.data_i[p]  = 32'h5000_0000 + p;
      end
      tick("rst.push");
      clear_in();
      chk("rst.count0", 256'(bus.count_o[PORT_N]), 256'(1));
      chk("rst.data4", 256'(bus.data_o[PORT_L]), 256'(32'h5000_0004));
      tick("rst.idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
